divider1: RTL and testbench

- Sequential restoring divider; the inverse of the team's shift-add multiplier.
- Divides an N-bit dividend by a D-bit divisor, producing one quotient bit per clock.
- Used in the MLP datapath for normalisation/averaging: it converts accumulated 16-bit products back to scaled values.
- Uses the same start/ready handshake style as the multiplier.

---
 rtl/divider1_if.sv | 36 +++
 rtl/divider1.sv | 142 ++++++++++++++
 tb/tb_divider1.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/divider1_if.sv
// rtl/divider1_if.sv - request/result bundle for the sequential restoring divider
//
// Purpose: groups the divider handshake and operand/result signals.
// Signals:
//   start        one-cycle request; operands sampled when accepted
//   dividend     N-bit unsigned numerator
//   divisor      D-bit unsigned denominator
//   quotient     N-bit registered quotient
//   remainder    D-bit registered remainder
//   ready        result valid; holds until the next accepted start
//   busy         iteration in progress
//   div_by_zero  last accepted operation had divisor == 0
// Modports: master (requester), slave (divider).
interface divider1_if #(
  parameter int N = 16,
  parameter int D = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [D-1:0] divisor;
  logic [N-1:0] quotient;
  logic [D-1:0] remainder;
  logic         ready;
  logic         busy;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, busy, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, busy, div_by_zero
  );
endinterface

// File: rtl/divider1.sv
// rtl/divider1.sv - sequential restoring divider, one quotient bit per clock
//
// Purpose: unsigned N-bit / D-bit division with a start/ready handshake.
// A nonzero divisor takes exactly N clocks from accept to ready; a zero
// divisor completes immediately with an all-ones quotient and div_by_zero set.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, priority over everything
//   bus  divider1_if.slave (start/dividend/divisor in,
//        quotient/remainder/ready/busy/div_by_zero out)
module divider1 #(
  parameter int N = 16,
  parameter int D = 8
) (
  input  logic      clk,
  input  logic      rst,
  divider1_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [N-1:0]  q_reg, q_nx;      // dividend shifting out, quotient bits shifting in
  logic [D-1:0]  v_reg, v_nx;      // latched divisor
  logic [D:0]    r_reg, r_nx;      // partial remainder, one guard bit
  logic [CW-1:0] cnt, cnt_nx;
  logic [N-1:0]  quo_reg, quo_nx;
  logic [D-1:0]  rem_reg, rem_nx;
  logic          ready_reg, ready_nx;
  logic          busy_reg, busy_nx;
  logic          dbz_reg, dbz_nx;

  // Trial value: remainder shifted left with the next dividend bit.
  // Since R < V always holds, R[D] is zero and the shifted value fits D+1 bits.
  logic [D:0]    trial;
  logic [D:0]    diff;
  logic          ge;
  logic [N-1:0]  q_shift;

  assign trial   = {r_reg[D-1:0], q_reg[N-1]};
  assign ge      = (trial >= {1'b0, v_reg});
  assign diff    = trial - {1'b0, v_reg};
  assign q_shift = {q_reg[N-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q_reg     <= '0;
      v_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      state     <= state_nx;
      q_reg     <= q_nx;
      v_reg     <= v_nx;
      r_reg     <= r_nx;
      cnt       <= cnt_nx;
      quo_reg   <= quo_nx;
      rem_reg   <= rem_nx;
      ready_reg <= ready_nx;
      busy_reg  <= busy_nx;
      dbz_reg   <= dbz_nx;
    end
  end

  always_comb begin
    state_nx = state;
    q_nx     = q_reg;
    v_nx     = v_reg;
    r_nx     = r_reg;
    cnt_nx   = cnt;
    quo_nx   = quo_reg;
    rem_nx   = rem_reg;
    ready_nx = ready_reg;
    busy_nx  = busy_reg;
    dbz_nx   = dbz_reg;

    case (state)
      IDLE, DONE: begin
        // DONE accepts a new start so results can be issued back-to-back.
        if (bus.start) begin
          q_nx     = bus.dividend;
          v_nx     = bus.divisor;
          r_nx     = '0;
          cnt_nx   = '0;
          ready_nx = 1'b0;
          dbz_nx   = 1'b0;
          if (bus.divisor == '0) begin
            // Zero divisor: publish the saturated result without iterating.
            state_nx = DONE;
            quo_nx   = '1;
            rem_nx   = '0;
            dbz_nx   = 1'b1;
            ready_nx = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            state_nx = BUSY;
            busy_nx  = 1'b1;
          end
        end
      end

      BUSY: begin
        // start is deliberately ignored here.
        q_nx   = q_shift;
        r_nx   = ge ? diff : trial;
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(N - 1)) begin
          state_nx = DONE;
          quo_nx   = q_shift;
          rem_nx   = ge ? diff[D-1:0] : trial[D-1:0];
          ready_nx = 1'b1;
          busy_nx  = 1'b0;
        end
      end

      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        ready_nx = 1'b0;
      end
    endcase
  end

  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rem_reg;
  assign bus.ready       = ready_reg;
  assign bus.busy        = busy_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider1.sv
// tb/tb_divider1.sv - directed and randomised checks of divider1
module tb_divider1;
  localparam int N = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  divider1_if #(.N(N), .D(D)) bus ();

  divider1 #(.N(N), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_miscompare = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the falling edge right after the accept edge.
  task automatic do_start(input logic [N-1:0] a, input logic [D-1:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Counts falling edges until ready; bounded.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!bus.ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] a, input logic [D-1:0] b,
                         input int exp_q, input int exp_r, input int exp_dbz, input int exp_lat);
    int c;
    do_start(a, b);
    wait_ready(c);
    check_val({tag, "_lat"}, c, exp_lat);
    check_val({tag, "_quo"}, bus.quotient, exp_q);
    check_val({tag, "_rem"}, bus.remainder, exp_r);
    check_val({tag, "_dbz"}, bus.div_by_zero, exp_dbz);
  endtask

  initial begin
    int c;
    int a, b;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check_val("rst_quo",   bus.quotient, 0);
    check_val("rst_rem",   bus.remainder, 0);
    check_val("rst_ready", bus.ready, 0);
    check_val("rst_busy",  bus.busy, 0);
    check_val("rst_dbz",   bus.div_by_zero, 0);
    rst = 1'b0;

    // Basic: 1000 / 7 = 142 r 6, busy visible after accept
    do_start(16'd1000, 8'd7);
    check_val("b1_busy",  bus.busy, 1);
    check_val("b1_ready", bus.ready, 0);
    wait_ready(c);
    check_val("b1_lat", c, 16);
    check_val("b1_quo", bus.quotient, 142);
    check_val("b1_rem", bus.remainder, 6);
    check_val("b1_dbz", bus.div_by_zero, 0);
    check_val("b1_busy_done", bus.busy, 0);

    // Max dividend, max divisor, then back-to-back from DONE
    run_div("maxdiv", 16'd65535, 8'd255, 257, 0, 0, 16);
    do_start(16'd65535, 8'd1);
    check_val("b2b_hold_quo", bus.quotient, 257);
    check_val("b2b_ready_low", bus.ready, 0);
    check_val("b2b_busy", bus.busy, 1);
    wait_ready(c);
    check_val("b2b_lat", c, 16);
    check_val("b2b_quo", bus.quotient, 65535);
    check_val("b2b_rem", bus.remainder, 0);

    // Dividend smaller than divisor, then divide by zero
    run_div("small", 16'd5, 8'd200, 0, 5, 0, 16);
    run_div("dbz", 16'd1234, 8'd0, 65535, 0, 1, 0);
    check_val("dbz_busy", bus.busy, 0);
    run_div("after_dbz", 16'd255, 8'd255, 1, 0, 0, 16);

    // start during BUSY is ignored
    do_start(16'd1000, 8'd7);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd9;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready(c);
    check_val("ign_lat", c + 5, 16);
    check_val("ign_quo", bus.quotient, 142);
    check_val("ign_rem", bus.remainder, 6);

    // Reset mid-operation
    do_start(16'd1000, 8'd7);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mrst_quo",   bus.quotient, 0);
    check_val("mrst_rem",   bus.remainder, 0);
    check_val("mrst_ready", bus.ready, 0);
    check_val("mrst_busy",  bus.busy, 0);
    repeat (20) @(negedge clk);
    check_val("mrst_idle_ready", bus.ready, 0);
    run_div("post_rst", 16'd300, 8'd10, 30, 0, 0, 16);

    // start and rst on the same edge: reset wins
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 8'd3;
    rst          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    check_val("srst_busy",  bus.busy, 0);
    check_val("srst_ready", bus.ready, 0);
    @(negedge clk);
    check_val("srst_idle_busy", bus.busy, 0);

    // Random sweep against integer reference
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(1, 255));
      do_start(a[N-1:0], b[D-1:0]);
      wait_ready(c);
      check_val("rnd_lat", c, 16);
      check_val("rnd_quo", bus.quotient, a / b);
      check_val("rnd_rem", bus.remainder, a % b);
      check_val("rnd_ident", int'(bus.quotient) * b + int'(bus.remainder), a);
      check_val("rnd_bound", (int'(bus.remainder) < b) ? 1 : 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
